// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : MIPS execute stage core - ALU control decode, 32-bit ALU and the
//            EX/MEM pipeline register feeding the MEM stage.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WORD-1:0] operand_a,
    input  logic [WORD-1:0] operand_b,
    input  logic [WORD-1:0] store_data,
    input  logic [5:0]      funct,
    input  logic [1:0]      alu_op,
    input  logic [4:0]      dest_reg,
    input  logic            mem_read_in,
    input  logic            mem_to_reg_in,
    input  logic            mem_write_in,
    input  logic            reg_write_in,
    output logic [3:0]      alu_ctrl,
    output logic [WORD-1:0] ex_alu_result,
    output logic            ex_zero,
    output logic [WORD-1:0] exmem_alu_result,
    output logic [WORD-1:0] exmem_store_data,
    output logic [4:0]      exmem_dest_reg,
    output logic            exmem_mem_read,
    output logic            exmem_mem_to_reg,
    output logic            exmem_mem_write,
    output logic            exmem_reg_write
);

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_NOR = 4'b1100;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;
    localparam logic [5:0] c_FN_NOR = 6'b100111;

    logic w_slt;

    always_comb begin
        alu_ctrl = c_ALU_ADD;
        case (alu_op)
            2'b00: alu_ctrl = c_ALU_ADD;
            2'b01: alu_ctrl = c_ALU_SUB;
            2'b11: alu_ctrl = c_ALU_AND;
            default: begin
                // Unrecognised R-type funct codes fall back to add
                case (funct)
                    c_FN_ADD: alu_ctrl = c_ALU_ADD;
                    c_FN_SUB: alu_ctrl = c_ALU_SUB;
                    c_FN_AND: alu_ctrl = c_ALU_AND;
                    c_FN_OR:  alu_ctrl = c_ALU_OR;
                    c_FN_SLT: alu_ctrl = c_ALU_SLT;
                    c_FN_NOR: alu_ctrl = c_ALU_NOR;
                    default:  alu_ctrl = c_ALU_ADD;
                endcase
            end
        endcase
    end

    assign w_slt = ($signed(operand_a) < $signed(operand_b));

    always_comb begin
        ex_alu_result = '0;
        case (alu_ctrl)
            c_ALU_AND: ex_alu_result = operand_a & operand_b;
            c_ALU_OR:  ex_alu_result = operand_a | operand_b;
            c_ALU_ADD: ex_alu_result = operand_a + operand_b;
            c_ALU_SUB: ex_alu_result = operand_a - operand_b;
            c_ALU_NOR: ex_alu_result = ~(operand_a | operand_b);
            c_ALU_SLT: ex_alu_result = {{(WORD-1){1'b0}}, w_slt};
            default:   ex_alu_result = '0;
        endcase
    end

    assign ex_zero = (ex_alu_result == '0);

    // Unconditional pipeline register; bubbles arrive as zeroed control bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_alu_result <= '0;
            exmem_store_data <= '0;
            exmem_dest_reg   <= '0;
            exmem_mem_read   <= 1'b0;
            exmem_mem_to_reg <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_reg_write  <= 1'b0;
        end else begin
            exmem_alu_result <= ex_alu_result;
            exmem_store_data <= store_data;
            exmem_dest_reg   <= dest_reg;
            exmem_mem_read   <= mem_read_in;
            exmem_mem_to_reg <= mem_to_reg_in;
            exmem_mem_write  <= mem_write_in;
            exmem_reg_write  <= reg_write_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Scoreboard bench for ex_mem_stage with directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand_a, operand_b, store_data;
    logic [5:0]  funct;
    logic [1:0]  alu_op;
    logic [4:0]  dest_reg;
    logic        mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in;
    logic [3:0]  alu_ctrl;
    logic [31:0] ex_alu_result;
    logic        ex_zero;
    logic [31:0] exmem_alu_result, exmem_store_data;
    logic [4:0]  exmem_dest_reg;
    logic        exmem_mem_read, exmem_mem_to_reg, exmem_mem_write, exmem_reg_write;

    ex_mem_stage #(.WORD(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .operand_a(operand_a), .operand_b(operand_b), .store_data(store_data),
        .funct(funct), .alu_op(alu_op), .dest_reg(dest_reg),
        .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in),
        .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
        .alu_ctrl(alu_ctrl), .ex_alu_result(ex_alu_result), .ex_zero(ex_zero),
        .exmem_alu_result(exmem_alu_result), .exmem_store_data(exmem_store_data),
        .exmem_dest_reg(exmem_dest_reg), .exmem_mem_read(exmem_mem_read),
        .exmem_mem_to_reg(exmem_mem_to_reg), .exmem_mem_write(exmem_mem_write),
        .exmem_reg_write(exmem_reg_write)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  dr;
        logic        mr, m2r, mw, rw;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: pick the operation the instruction asks for, then evaluate it
    function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [3:0] ctl, output logic [31:0] res);
        string name;
        if (op == 2'b00)      name = "add";
        else if (op == 2'b01) name = "sub";
        else if (op == 2'b11) name = "and";
        else if (fn == 6'd32) name = "add";
        else if (fn == 6'd34) name = "sub";
        else if (fn == 6'd36) name = "and";
        else if (fn == 6'd37) name = "or";
        else if (fn == 6'd42) name = "slt";
        else if (fn == 6'd39) name = "nor";
        else                  name = "add";
        case (name)
            "add": begin ctl = 4'd2;  res = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000); end
            "sub": begin ctl = 4'd6;  res = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000); end
            "and": begin ctl = 4'd0;  res = a & b; end
            "or":  begin ctl = 4'd1;  res = a | b; end
            "nor": begin ctl = 4'd12; res = 32'hFFFF_FFFF ^ (a | b); end
            default: begin
                ctl = 4'd7;
                res = ((longint'($signed(a)) < longint'($signed(b)))) ? 32'd1 : 32'd0;
            end
        endcase
    endfunction

    task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                         input logic [4:0] dr, input logic [3:0] ctl_bits);
        logic [3:0]  ectl;
        logic [31:0] eres;
        exp_t        e;
        @(negedge clk);
        alu_op = op; funct = fn; operand_a = a; operand_b = b; store_data = sd;
        dest_reg = dr;
        {mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in} = ctl_bits;
        #1;
        model(op, fn, a, b, ectl, eres);
        chk("alu_ctrl", 64'(alu_ctrl), 64'(ectl));
        chk("ex_alu_result", 64'(ex_alu_result), 64'(eres));
        chk("ex_zero", 64'(ex_zero), 64'(eres == 32'd0));
        e.res = eres; e.sd = sd; e.dr = dr;
        {e.mr, e.m2r, e.mw, e.rw} = ctl_bits;
        q.push_back(e);
    endtask

    task automatic chk_regs_zero(input string nm);
        chk(nm, {exmem_alu_result, exmem_store_data} , 64'd0);
        chk({nm, "_ctl"}, 64'({exmem_dest_reg, exmem_mem_read, exmem_mem_to_reg,
                               exmem_mem_write, exmem_reg_write}), 64'd0);
    endtask

    // Monitor: each active edge out of reset presents one captured instruction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                chk("exmem_alu_result", 64'(exmem_alu_result), 64'(e.res));
                chk("exmem_store_data", 64'(exmem_store_data), 64'(e.sd));
                chk("exmem_dest_reg",   64'(exmem_dest_reg),   64'(e.dr));
                chk("exmem_ctl", 64'({exmem_mem_read, exmem_mem_to_reg, exmem_mem_write,
                                      exmem_reg_write}), 64'({e.mr, e.m2r, e.mw, e.rw}));
            end
        end
    end

    initial begin
        logic [5:0]  fns [7] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0};
        logic [31:0] edges [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        operand_a = 32'h1234_5678; operand_b = 32'h1111_1111; store_data = 32'hCAFE_F00D;
        funct = 6'd32; alu_op = 2'b10; dest_reg = 5'd17;
        {mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in} = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_regs_zero("reset_hold");
        chk("ex_alu_result_in_reset", 64'(ex_alu_result), 64'h2345_6789);
        rst_n = 1'b1;

        // R-type decode
        drive(2'b10, 6'b100000, 32'd7, 32'd5, 32'h0, 5'd3, 4'b0001);
        chk("rtype_add", 64'(ex_alu_result), 64'd12);
        drive(2'b10, 6'b100010, 32'd7, 32'd5, 32'h0, 5'd4, 4'b0001);
        chk("rtype_sub", 64'(ex_alu_result), 64'd2);
        drive(2'b10, 6'b100100, 32'd7, 32'd5, 32'h0, 5'd5, 4'b0001);
        chk("rtype_and", 64'(ex_alu_result), 64'd5);
        drive(2'b10, 6'b100101, 32'd7, 32'd5, 32'h0, 5'd6, 4'b0001);
        chk("rtype_or", 64'(ex_alu_result), 64'd7);
        drive(2'b10, 6'b100111, 32'd7, 32'd5, 32'h0, 5'd7, 4'b0001);
        chk("rtype_nor", 64'(ex_alu_result), 64'hFFFF_FFF8);
        chk("rtype_nor_ctl", 64'(alu_ctrl), 64'hC);

        // Signed compare
        drive(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd8, 4'b0001);
        chk("slt_neg_lt_pos", 64'(ex_alu_result), 64'd1);
        drive(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'h0, 5'd8, 4'b0001);
        chk("slt_pos_lt_neg", 64'(ex_alu_result), 64'd0);
        drive(2'b10, 6'b101010, 32'd42, 32'd42, 32'h0, 5'd8, 4'b0001);
        chk("slt_equal_zero", 64'(ex_zero), 64'd1);

        // Store path, wrap-around add, sub, unknown funct
        drive(2'b00, 6'b000000, 32'h100, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 5'd9, 4'b0010);
        chk("sw_addr", 64'(ex_alu_result), 64'hFC);
        drive(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd1, 4'b1101);
        chk("wrap_zero", 64'(ex_zero), 64'd1);
        drive(2'b01, 6'b000000, 32'd3, 32'd5, 32'h0, 5'd0, 4'b0000);
        chk("sub_neg", 64'(ex_alu_result), 64'hFFFF_FFFE);
        drive(2'b10, 6'b000000, 32'd20, 32'd22, 32'h5, 5'd31, 4'b0001);
        chk("unknown_funct_add", 64'(ex_alu_result), 64'd42);

        // Asynchronous reset between edges discards in-flight state
        drive(2'b11, 6'b000000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h1, 5'd2, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        chk_regs_zero("async_reset");
        q.delete();
        @(posedge clk);
        #2;
        chk_regs_zero("reset_held_over_edge");
        @(negedge clk);
        rst_n = 1'b1;

        // Random back-to-back traffic
        for (int i = 0; i < 200; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? ra :
                 (($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom);
            drive(2'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1) ? fns[$urandom_range(0, 6)] : 6'($urandom),
                  ra, rb, $urandom, 5'($urandom), 4'($urandom));
        end

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-stage datapath core of the 5-stage MIPS pipeline: ALU-control decode, 32-bit ALU, and the EX/MEM pipeline register.
- Sits after the EX forwarding/ALUSrc muxes, which supply the final operands.
- Latches the ALU result, store data, destination register and MEM/WB control bits on each clock edge for the MEM stage.

Parameters:
WORD, 32, datapath width (operands, result, store data)

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
operand_a  input  WORD  ALU operand 1 (post-forwarding)
operand_b  input  WORD  ALU operand 2 (post-ALUSrc mux)
store_data  input  WORD  forwarded rt value, to be stored by sw
funct  input  6  instruction bits [5:0] (low bits of sign-extended immediate)
alu_op  input  2  ALUOp from main control
dest_reg  input  5  destination register from the RegDst mux
mem_read_in  input  1  MemRead control
mem_to_reg_in  input  1  MemtoReg control
mem_write_in  input  1  MemWrite control
reg_write_in  input  1  RegWrite control
alu_ctrl  output  4  decoded ALU control (combinational)
ex_alu_result  output  WORD  combinational ALU result
ex_zero  output  1  1 when ex_alu_result == 0 (combinational)
exmem_alu_result  output  WORD  registered ALU result
exmem_store_data  output  WORD  registered store data
exmem_dest_reg  output  5  registered destination register
exmem_mem_read  output  1  registered MemRead
exmem_mem_to_reg  output  1  registered MemtoReg
exmem_mem_write  output  1  registered MemWrite
exmem_reg_write  output  1  registered RegWrite

Behaviour:
- ALU control, combinational:
  - alu_op 00 -> 0010 (add; lw/sw address)
  - alu_op 01 -> 0110 (sub)
  - alu_op 11 -> 0000 (and)
  - alu_op 10 decodes funct: 100000 add->0010; 100010 sub->0110; 100100 and->0000; 100101 or->0001; 101010 slt->0111; 100111 nor->1100; any other funct -> 0010.
- ALU, combinational, on alu_ctrl:
  - 0000 a&b; 0001 a|b; 0010 a+b; 0110 a-b; 1100 ~(a|b).
  - 0111 signed compare: result 1 if a<b (two's complement), else 0.
  - Add/sub wrap modulo 2^WORD; no overflow flag or trap.
  - Any other code -> result 0.
- ex_zero = (ex_alu_result == 0).
- EX/MEM register:
  - On each rising clk with rst_n high, captures ex_alu_result, store_data, dest_reg and the four control bits.
  - Unconditional: no stall or enable, no flush input. Bubbles arrive from upstream as zeroed control bits.
  - Latency 1 cycle: inputs present before edge N appear on exmem_* after edge N.
- Reset:
  - rst_n low immediately (asynchronously) forces every exmem_* output to 0, independent of clk.
  - Register holds 0 while rst_n is low.
  - First capture happens on the first rising edge after rst_n deasserts.
  - Reset asserted mid-operation discards in-flight contents.
  - Combinational outputs (alu_ctrl, ex_alu_result, ex_zero) are unaffected by reset.
- Control bits pass through unmodified: no check for mem_read and mem_write both high, no special handling of dest_reg=0.

Test Plan:
- Reset: drive all inputs nonzero, pulse rst_n low between edges -> all exmem_* read 0 immediately. Deassert, clock once -> inputs captured.
- R-type decode: alu_op=10, a=7, b=5, funct 100000/100010/100100/100101/100111 -> results 12, 2, 5, 7, 0xFFFFFFF8; alu_ctrl 0010/0110/0000/0001/1100.
- slt signed: alu_op=10, funct 101010:
  - a=0xFFFFFFFF, b=1 -> 1.
  - a=1, b=0xFFFFFFFF -> 0.
  - a=b -> 0, ex_zero=1.
- lw/sw path: alu_op=00, a=0x100, b=0xFFFFFFFC, store_data=0xDEADBEEF, dest_reg=9, mem_write=1 -> after one edge:
  - exmem_alu_result=0xFC
  - exmem_store_data=0xDEADBEEF
  - exmem_dest_reg=9
  - exmem_mem_write=1, other control bits 0.
- Wrap and sub: alu_op=00, a=0xFFFFFFFF, b=1 -> result 0, ex_zero=1. alu_op=01, a=3, b=5 -> 0xFFFFFFFE.
- Back-to-back pipeline: change inputs every cycle for 4 cycles -> exmem_* track each cycle's inputs exactly one edge later, no drops or duplicates. Unknown funct 000000 with alu_op=10 -> add behaviour.
